// File: rtl/present_pkg.sv
// PRESENT-80 shared definitions: S-box tables, key schedule steps, FSM states.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package present_pkg;

    localparam int KEY_W  = 80;
    localparam int BLK_W  = 64;
    localparam int ROUNDS = 31;
    localparam int RC_W   = 5;

    // Nibble n of each table is the substitution of value n.
    localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] INV_SBOX = 64'hA970364BD21C8FE5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEXP = 2'd1,
        DEC  = 2'd2,
        DONE = 2'd3
    } fsm_t;

    function automatic logic [3:0] sbox(input logic [3:0] n);
        return SBOX[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] n);
        return INV_SBOX[{n, 2'b00} +: 4];
    endfunction

    // One forward key-schedule step using round counter rc.
    function automatic logic [KEY_W-1:0] fwd_key_update(input logic [KEY_W-1:0] k,
                                                         input logic [RC_W-1:0]  rc);
        logic [KEY_W-1:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ rc;
        return t;
    endfunction

    // Undoes fwd_key_update for the same rc: XOR, inverse S-box, rotate right 61.
    function automatic logic [KEY_W-1:0] inv_key_update(input logic [KEY_W-1:0] k,
                                                         input logic [RC_W-1:0]  rc);
        logic [KEY_W-1:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ rc;
        t[79:76]   = inv_sbox(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

endpackage

// File: rtl/inv_sub_per.sv
// Inverse PRESENT round core: inverse bit permutation, then inverse S-box on all nibbles.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module inv_sub_per
    import present_pkg::*;
(
    input  logic [BLK_W-1:0] blk,
    output logic [BLK_W-1:0] inv_blk
);

    logic [BLK_W-1:0] perm;

    // Forward P moves bit i to 16*i mod 63, so the inverse gathers from there.
    always_comb begin
        perm = '0;
        for (int i = 0; i < BLK_W - 1; i++) begin
            perm[i] = blk[(i * 16) % 63];
        end
        perm[BLK_W-1] = blk[BLK_W-1];
        inv_blk = '0;
        for (int j = 0; j < BLK_W / 4; j++) begin
            inv_blk[4*j +: 4] = inv_sbox(perm[4*j +: 4]);
        end
    end

endmodule

// File: rtl/present_decryptor.sv
// PRESENT-80 decryptor: one-time key expansion to K32, then one inverse round per cycle.
// Latency: 31 cycles key expansion; 31 cycles from ciphertext accept to data_valid_o.
// Backpressure: result held in DONE until data_ready_i; optional PRESENT_DEC_ZEROIZE_EN masks/clears data.
module present_decryptor
    import present_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [KEY_W-1:0]  key_i,
    input  logic              key_load_i,
    input  logic [BLK_W-1:0]  data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic [BLK_W-1:0]  data_o,
    output logic              data_valid_o,
    input  logic              data_ready_i,
    output logic              key_ready_o
);

    fsm_t             fsm;
    fsm_t             fsm_nxt;
    logic [BLK_W-1:0] state_reg;
    logic [BLK_W-1:0] isp_out;
    logic [KEY_W-1:0] kreg;
    logic [KEY_W-1:0] dec_key;
    logic [RC_W-1:0]  rc;
    logic             accept;
    logic             handshake;

    inv_sub_per u_isp (
        .blk     (state_reg),
        .inv_blk (isp_out)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    // Next-state logic; a key load in IDLE beats a pending ciphertext.
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE: begin
                if (key_load_i) begin
                    fsm_nxt = KEXP;
                end else if (accept) begin
                    fsm_nxt = DEC;
                end
            end
            KEXP:    if (rc == RC_W'(ROUNDS)) fsm_nxt = IDLE;
            DEC:     if (rc == RC_W'(1))      fsm_nxt = DONE;
            DONE:    if (handshake)           fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    // Handshake outputs and the strobes derived from them.
    always_comb begin
        data_ready_o = (fsm == IDLE) && key_ready_o && !key_load_i;
        data_valid_o = (fsm == DONE);
        accept       = data_ready_o && data_valid_i;
        handshake    = data_valid_o && data_ready_i;
    end

`ifdef PRESENT_DEC_ZEROIZE_EN
    assign data_o = data_valid_o ? state_reg : '0;
`else
    assign data_o = state_reg;
`endif

    // Datapath: key expansion, whitening with K32, then rounds 31 down to 1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= '0;
            kreg        <= '0;
            dec_key     <= '0;
            rc          <= '0;
            key_ready_o <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (key_load_i) begin
                        kreg        <= key_i;
                        rc          <= RC_W'(1);
                        key_ready_o <= 1'b0;
                    end else if (accept) begin
                        state_reg <= data_i ^ dec_key[79:16];
                        kreg      <= inv_key_update(dec_key, RC_W'(ROUNDS));
                        rc        <= RC_W'(ROUNDS);
                    end
                end
                KEXP: begin
                    kreg <= fwd_key_update(kreg, rc);
                    rc   <= rc + RC_W'(1);
                    if (rc == RC_W'(ROUNDS)) begin
                        dec_key     <= fwd_key_update(kreg, rc);
                        key_ready_o <= 1'b1;
                    end
                end
                DEC: begin
                    state_reg <= isp_out ^ kreg[79:16];
                    kreg      <= inv_key_update(kreg, rc - RC_W'(1));
                    rc        <= rc - RC_W'(1);
                end
                DONE: begin
`ifdef PRESENT_DEC_ZEROIZE_EN
                    if (handshake) begin
                        state_reg <= '0;
                        kreg      <= '0;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_present_decryptor.sv
// Randomized scoreboard bench for present_decryptor with a PRESENT-80 encryption model.
// Latency: checks 31-cycle decrypt latency and 33-cycle back-to-back accept spacing.
// Backpressure: exercises data_ready_i held low and reset aborts.
module tb_present_decryptor;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [79:0] key_i;
    logic        key_load_i;
    logic [63:0] data_i;
    logic        data_valid_i;
    logic        data_ready_o;
    logic [63:0] data_o;
    logic        data_valid_o;
    logic        data_ready_i;
    logic        key_ready_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [63:0] exp_q[$];
    int          acc_q[$];

    localparam logic [3:0] SB [0:15] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    present_decryptor dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .key_i        (key_i),
        .key_load_i   (key_load_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .key_ready_o  (key_ready_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Textbook PRESENT-80 encryption: 31 rounds of addRoundKey/sLayer/pLayer plus final key.
    function automatic logic [63:0] ref_enc(input logic [79:0] key, input logic [63:0] pt);
        logic [79:0] k;
        logic [63:0] s;
        logic [63:0] t;
        k = key;
        s = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int j = 0; j < 16; j++) s[4*j +: 4] = SB[s[4*j +: 4]];
            t = '0;
            for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
            s = t;
            k = (k << 61) | (k >> 19);
            k[79:76] = SB[k[79:76]];
            k[19:15] = k[19:15] ^ r[4:0];
        end
        return s ^ k[79:16];
    endfunction

    task automatic load_key(input logic [79:0] k, input bit with_data);
        int n;
        key_i        = k;
        key_load_i   = 1'b1;
        if (with_data) begin
            data_i       = {$urandom(), $urandom()};
            data_valid_i = 1'b1;
        end
        @(negedge clk);
        if (with_data) chk("kload_priority_ready", 64'(data_ready_o), 64'd0);
        @(posedge clk);
        #1;
        key_load_i   = 1'b0;
        data_valid_i = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (key_ready_o) break;
            n++;
        end
        chk("kexp_cycles", 64'(n), 64'd31);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] ct, input logic [63:0] exp, input bit keep_valid,
                        output int acc);
        data_i       = ct;
        data_valid_i = 1'b1;
        acc          = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (data_ready_o) begin
                acc = cyc + 1;
                exp_q.push_back(exp);
                acc_q.push_back(acc);
                break;
            end
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no data_ready_o expected accept within 200 cycles");
        end
        @(posedge clk);
        #1;
        if (!keep_valid) data_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented result with the scoreboard head.
    initial begin
        bit prev_vld;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_vld = 1'b0;
            end else begin
                if (data_valid_o) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got data_valid_o=1 data_o=%h expected no output", data_o);
                    end else begin
                        if (!prev_vld) chk("latency", 64'(cyc - acc_q[0]), 64'd31);
                        chk("data", data_o, exp_q[0]);
                        if (data_ready_i) begin
                            void'(exp_q.pop_front());
                            void'(acc_q.pop_front());
                        end
                    end
                end
`ifdef PRESENT_DEC_ZEROIZE_EN
                else begin
                    chk("zeroize_data", data_o, 64'h0);
                end
`endif
                prev_vld = data_valid_o && !data_ready_i;
            end
        end
    end

    initial begin
        int          acc;
        int          prev;
        bit          rdy_seen;
        logic [79:0] key;
        logic [63:0] pt;

        rst_i        = 1'b1;
        key_i        = '0;
        key_load_i   = 1'b0;
        data_i       = '0;
        data_valid_i = 1'b0;
        data_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;

        @(negedge clk);
        chk("rst_valid", 64'(data_valid_o), 64'd0);
        chk("rst_ready", 64'(data_ready_o), 64'd0);
        chk("rst_key_ready", 64'(key_ready_o), 64'd0);
        chk("rst_data", data_o, 64'h0);
        @(posedge clk);
        #1;

        // Zero key, then a reload with a simultaneous ciphertext: the load must win.
        load_key(80'h0, 1'b0);
        load_key(80'h0, 1'b1);
        send(64'h5579C1387B228445, 64'h0, 1'b0, acc);
        wait_drain();

        // All-ones key, two blocks without reloading.
        load_key({80{1'b1}}, 1'b0);
        send(64'hE72C46C0F5945049, 64'h0, 1'b0, acc);
        wait_drain();
        send(64'h3333DCD3213210D2, {64{1'b1}}, 1'b0, acc);
        wait_drain();

        // Output stalled for 10 cycles.
        load_key(80'h0, 1'b0);
        data_ready_i = 1'b0;
        send(64'hA112FFC72F68417B, {64{1'b1}}, 1'b0, acc);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (data_valid_o) break;
        end
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 64'(data_valid_o), 64'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        data_ready_i = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_after_hs_valid", 64'(data_valid_o), 64'd0);
        chk("idle_after_hs_ready", 64'(data_ready_o), 64'd1);
        wait_drain();

        // Reset in the middle of decryption aborts the block and drops the key.
        key = {16'($urandom()), $urandom(), $urandom()};
        load_key(key, 1'b0);
        send({$urandom(), $urandom()}, 64'h0, 1'b0, acc);
        repeat (15) @(posedge clk);
        #1;
        rst_i = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_key_ready", 64'(key_ready_o), 64'd0);
        chk("abort_data", data_o, 64'h0);
        data_i       = {$urandom(), $urandom()};
        data_valid_i = 1'b1;
        rdy_seen     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (data_ready_o) rdy_seen = 1'b1;
        end
        chk("abort_no_ready", 64'(rdy_seen), 64'd0);
        @(posedge clk);
        #1;
        data_valid_i = 1'b0;

        // Random keys, back-to-back random blocks with the sink always ready.
        data_ready_i = 1'b1;
        for (int kk = 0; kk < 4; kk++) begin
            key = {16'($urandom()), $urandom(), $urandom()};
            load_key(key, 1'b0);
            prev = -1;
            for (int b = 0; b < 4; b++) begin
                pt = {$urandom(), $urandom()};
                send(ref_enc(key, pt), pt, 1'b1, acc);
                if (prev >= 0) chk("b2b_spacing", 64'(acc - prev), 64'd33);
                prev = acc;
            end
            data_valid_i = 1'b0;
            wait_drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/present_decryptor.md
PRESENT_DECRYPTOR -- requirements
Module: present_decryptor

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset: clk_i  in  1  rising-edge clock; rst_i  in  1  synchronous active-high reset.
REQ-002 The block SHALL have key_i  in  80  cipher key (same 80-bit key used for encryption).
REQ-003 The block SHALL have key_load_i  in  1  key-load strobe, sampled only in IDLE.
REQ-004 The block SHALL have data_i  in  64  ciphertext block.
REQ-005 The block SHALL have data_valid_i  in  1  ciphertext valid.
REQ-006 The block SHALL have data_ready_o  out  1  ciphertext accepted when data_valid_i and data_ready_o are both high.
REQ-007 The block SHALL have data_o  out  64  recovered plaintext.
REQ-008 The block SHALL have data_valid_o  out  1  plaintext valid.
REQ-009 The block SHALL have data_ready_i  in  1  plaintext taken when data_valid_o and data_ready_i are both high.
REQ-010 The block SHALL have key_ready_o  out  1  high when an expanded decryption key is held.

Function
REQ-011 The FSM SHALL have states IDLE, KEXP, DEC, DONE.
REQ-012 IDLE + key_load_i SHALL latch key_i into the key register, set rc=1, clear key_ready_o, and go to KEXP; key_load_i takes priority over data_valid_i in the same cycle.
REQ-013 KEXP SHALL apply the forward key update (rotate left 61, S-box on bits [79:76], XOR rc into bits [19:15]) once per cycle for rc=1..31; after rc=31 it stores K32 in dec_key, sets key_ready_o, and returns to IDLE (31 cycles).
REQ-014 data_ready_o SHALL equal (state==IDLE && key_ready_o && !key_load_i).
REQ-015 On accept, the block SHALL set state <= data_i ^ dec_key[79:16], set kreg <= inv_update(dec_key,31), set rc=31, and go to DEC.
REQ-016 inv_update(k,i) SHALL XOR i into [19:15], apply the inverse S-box on [79:76], and rotate right 61; it is the exact inverse of the forward update with counter i.
REQ-017 Each DEC cycle SHALL set state <= invS(invP(state)) ^ kreg[79:16] (inverse permutation first, then inverse S-box on all 16 nibbles), set kreg <= inv_update(kreg,rc-1), and decrement rc; when rc==1 in DEC, the next state is DONE.
REQ-018 Latency SHALL be 31 cycles from the accept edge to data_valid_o high; data_o holds the plaintext in DONE.
REQ-019 DONE SHALL hold data_o and data_valid_o stable until data_ready_i; on the handshake it returns to IDLE, and the next accept can occur in the following cycle.
REQ-020 key_load_i and data_valid_i outside IDLE SHALL be ignored and SHALL not corrupt dec_key.
REQ-021 dec_key SHALL persist across blocks; no re-expansion is needed per block.

Reset
REQ-022 rst_i SHALL take priority over all inputs and force IDLE, key_ready_o=0, data_valid_o=0, data_ready_o=0, rc=0, and state/kreg/dec_key=0.
REQ-023 rst_i mid-KEXP or mid-DEC SHALL abort the operation; no data_valid_o is asserted for the aborted block.

Configuration
REQ-024 With PRESENT_DEC_ZEROIZE_EN defined, data_o SHALL be 64'h0 whenever data_valid_o=0, and kreg/state SHALL be cleared on the DONE handshake.
REQ-025 Without PRESENT_DEC_ZEROIZE_EN, data_o SHALL expose the internal state register at all times, with no clearing.

Structure
REQ-026 Package present_pkg SHALL hold SBOX and INV_SBOX tables, the ROUNDS=31 constant, KEY_W=80 and BLK_W=64, the FSM state enum, and the fwd_key_update/inv_key_update functions.
REQ-027 The inverse substitution-permutation network SHALL be a single combinational sub-module, inv_sub_per (64 in, 64 out).

Verification
REQ-028 Key 80'h0, ct 64'h5579C1387B228445 -> data_o 64'h0 exactly 31 cycles after accept.
REQ-029 Key 80'hFFFF_FFFFFFFF_FFFFFFFF, ct 64'hE72C46C0F5945049 -> data_o 64'h0; then ct 64'h3333DCD3213210D2 without reload -> data_o 64'hFFFFFFFFFFFFFFFF.
REQ-030 Key 80'h0, ct 64'hA112FFC72F68417B with data_ready_i held low 10 cycles -> data_o 64'hFFFFFFFFFFFFFFFF stable and data_valid_o high throughout; IDLE follows the handshake.
REQ-031 key_load_i and data_valid_i high together in IDLE -> key load wins; data_ready_o=0 for 31 KEXP cycles, then key_ready_o=1.
REQ-032 rst_i pulsed at DEC cycle 15 -> data_valid_o never asserts; key_ready_o=0; a data_valid_i sent without reloading the key -> data_ready_o stays 0.
REQ-033 Back-to-back blocks with data_ready_i=1 -> accepts occur 33 cycles apart, and each result matches the encryptor for random key/plaintext pairs.
